pll_lock_supervisor: RTL and testbench

- Supervises the clocking PLL from the 50 MHz reference domain.
- Synchronises the PLL's raw `locked` output into the refclk domain.
- Drives the PLL reset input with a timed pulse, requires lock to be continuously stable before releasing the downstream system reset, and retries the PLL on lock timeout or lock loss.
- Sits between the board reset and the PLL on one side, and all consumers of the PLL output clocks on the other.

---
 rtl/pll_lock_supervisor.sv | 143 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_supervisor
// Brief    : Times the PLL reset pulse, qualifies lock stability, and gates
//            the downstream reset. Retries the PLL on timeout or lock loss.
// Revision : 1.0  initial release
// ============================================================================
module pll_lock_supervisor #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W               = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked_in,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_s,
  output logic [7:0] retry_count,
  output logic [7:0] relock_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       C_CNT_MAX      = 8'hFF;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [7:0]             r_retry;
  logic [7:0]             w_retry_nxt;
  logic [7:0]             r_relock;
  logic [7:0]             w_relock_nxt;
  logic                   r_pll_rst;
  logic                   r_sys_rst;
  logic                   r_ready;
  logic                   w_lock;

  // locked_in is asynchronous; only the last stage is ever used by the FSM.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], locked_in};
    end
  end

  assign w_lock = r_sync[SYNC_STAGES-1];

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state   <= ST_PLL_RST;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_relock  <= '0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_retry   <= w_retry_nxt;
      r_relock  <= w_relock_nxt;
      r_pll_rst <= (w_state_nxt == ST_PLL_RST);
      r_sys_rst <= (w_state_nxt != ST_RUN);
      r_ready   <= (w_state_nxt == ST_RUN);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CNT_W'(1);
    w_retry_nxt  = r_retry;
    w_relock_nxt = r_relock;
    case (r_state)
      ST_PLL_RST: begin
        if (r_cnt == C_RST_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes precedence over a timeout landing on the same cycle.
        if (w_lock) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_TIMEOUT_LAST) begin
          w_state_nxt = ST_PLL_RST;
          w_cnt_nxt   = '0;
          if (r_retry != C_CNT_MAX) begin
            w_retry_nxt = r_retry + 8'd1;
          end
        end
      end
      ST_STABLE: begin
        if (!w_lock) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_STABLE_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = '0;
        if (!w_lock) begin
          w_state_nxt = ST_PLL_RST;
          if (r_relock != C_CNT_MAX) begin
            w_relock_nxt = r_relock + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_PLL_RST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign pll_rst      = r_pll_rst;
  assign sys_rst      = r_sys_rst;
  assign ready        = r_ready;
  assign lock_s       = w_lock;
  assign retry_count  = r_retry;
  assign relock_count = r_relock;
  assign state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_lock_supervisor
// Brief    : Directed bench for pll_lock_supervisor with hand-computed timing.
// Revision : 1.0  initial release
// ============================================================================
module tb_pll_lock_supervisor;

  localparam int SYNC_STAGES         = 2;
  localparam int PLL_RST_CYCLES      = 4;
  localparam int LOCK_STABLE_CYCLES  = 8;
  localparam int LOCK_TIMEOUT_CYCLES = 32;
  localparam int CNT_W               = 20;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked_in = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_s;
  logic [7:0] retry_count;
  logic [7:0] relock_count;
  logic [1:0] state;

  int n_cmp  = 0;
  int n_err  = 0;
  bit inv_en = 1'b0;

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(
    .SYNC_STAGES        (SYNC_STAGES),
    .PLL_RST_CYCLES     (PLL_RST_CYCLES),
    .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
    .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
    .CNT_W              (CNT_W)
  ) u_dut (
    .refclk      (refclk),
    .rst         (rst),
    .locked_in   (locked_in),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .lock_s      (lock_s),
    .retry_count (retry_count),
    .relock_count(relock_count),
    .state       (state)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic check_outs(input string tag, input int st, input bit prst, input bit srst);
    check_val({tag, "_state"}, 32'(state), 32'(st));
    check_val({tag, "_pll_rst"}, 32'(pll_rst), 32'(prst));
    check_val({tag, "_sys_rst"}, 32'(sys_rst), 32'(srst));
    check_val({tag, "_ready"}, 32'(ready), 32'(!srst));
  endtask

  // Invariants sampled on the falling edge, away from the active edge.
  always @(negedge refclk) begin
    if (inv_en) begin
      check_val("inv_sys_ready", 32'(sys_rst ^ ready), 32'd1);
      check_val("inv_pll_rst_state", 32'(pll_rst && (state != 2'd0)), 32'd0);
      check_val("inv_sys_rst_state", 32'(!sys_rst && (state != 2'd3)), 32'd0);
    end
  end

  // Three reset edges, release, then the 4-cycle PLL pulse; leaves WAIT_LOCK with cnt=0.
  task automatic reset_seq();
    rst       = 1'b1;
    locked_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      inv_en = 1'b1;
      check_outs("rst", 0, 1'b1, 1'b1);
      check_val("rst_retry", 32'(retry_count), 32'd0);
      check_val("rst_relock", 32'(relock_count), 32'd0);
      check_val("rst_lock_s", 32'(lock_s), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_outs("prst_pulse", 0, 1'b1, 1'b1);
    end
    tick(1);
    check_outs("wait_entry", 1, 1'b0, 1'b1);
  endtask

  // Raise locked_in after 'pre' cycles in WAIT_LOCK; ready must rise on the 11th edge.
  task automatic lock_up(input int pre);
    tick(pre);
    locked_in = 1'b1;
    tick(2);
    check_val("lk_wait_state", 32'(state), 32'd1);
    check_val("lk_lock_s", 32'(lock_s), 32'd1);
    tick(1);
    check_val("lk_stable_state", 32'(state), 32'd2);
    tick(7);
    check_outs("lk_pre_release", 2, 1'b0, 1'b1);
    tick(1);
    check_outs("lk_release", 3, 1'b0, 1'b0);
  endtask

  initial begin
    // Power-up
    reset_seq();
    lock_up(6);
    check_val("pu_retry", 32'(retry_count), 32'd0);
    check_val("pu_relock", 32'(relock_count), 32'd0);

    // Lock loss in RUN
    locked_in = 1'b0;
    tick(2);
    check_outs("loss_still_run", 3, 1'b0, 1'b0);
    tick(1);
    check_outs("loss_drop", 0, 1'b1, 1'b1);
    check_val("loss_relock", 32'(relock_count), 32'd1);
    tick(3);
    check_val("loss_prst_hold", 32'(pll_rst), 32'd1);
    tick(1);
    check_outs("loss_wait", 1, 1'b0, 1'b1);
    lock_up(0);
    check_val("loss_relock_after", 32'(relock_count), 32'd1);
    check_val("loss_retry_after", 32'(retry_count), 32'd0);

    // Reset during RUN clears relock_count, then a full bring-up
    reset_seq();
    lock_up(0);

    // Single-cycle glitch in STABLE, dropping on the completing cycle
    reset_seq();
    locked_in = 1'b1;
    tick(3);
    check_val("gl_stable", 32'(state), 32'd2);
    tick(5);
    locked_in = 1'b0;
    tick(1);
    check_val("gl_g1", 32'(state), 32'd2);
    locked_in = 1'b1;
    tick(1);
    check_val("gl_g2", 32'(state), 32'd2);
    tick(1);
    check_outs("gl_g3_wait", 1, 1'b0, 1'b1);
    tick(1);
    check_val("gl_g4_stable", 32'(state), 32'd2);
    tick(7);
    check_outs("gl_g11", 2, 1'b0, 1'b1);
    tick(1);
    check_outs("gl_g12_run", 3, 1'b0, 1'b0);
    check_val("gl_relock", 32'(relock_count), 32'd0);

    // Lock arriving on the timeout cycle wins
    reset_seq();
    tick(29);
    locked_in = 1'b1;
    tick(2);
    check_val("sim_cnt31_state", 32'(state), 32'd1);
    tick(1);
    check_outs("sim_stable", 2, 1'b0, 1'b1);
    check_val("sim_retry", 32'(retry_count), 32'd0);

    // Repeated timeouts with saturation of retry_count
    reset_seq();
    for (int k = 1; k <= 300; k++) begin
      tick(31);
      check_outs("to_wait", 1, 1'b0, 1'b1);
      tick(1);
      check_outs("to_pulse", 0, 1'b1, 1'b1);
      check_val("to_retry", 32'(retry_count), 32'((k > 255) ? 255 : k));
      tick(3);
      check_val("to_pulse_hold", 32'(pll_rst), 32'd1);
      tick(1);
      check_outs("to_rewait", 1, 1'b0, 1'b1);
    end
    check_val("to_retry_sat", 32'(retry_count), 32'd255);

    // Reset during STABLE with cnt=5
    locked_in = 1'b1;
    tick(3);
    tick(5);
    check_val("rs_stable", 32'(state), 32'd2);
    rst = 1'b1;
    tick(1);
    check_outs("rs_reset", 0, 1'b1, 1'b1);
    check_val("rs_retry", 32'(retry_count), 32'd0);
    check_val("rs_relock", 32'(relock_count), 32'd0);
    reset_seq();
    lock_up(6);
    check_val("rs_final_retry", 32'(retry_count), 32'd0);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
